ks_keyed_seq_core: RTL and testbench



---
 rtl/ks_lock_pkg.sv | 17 +
 rtl/ks_lfsr.sv | 13 +
 rtl/ks_keyed_seq_core.sv | 148 ++++++++++++++
 tb/tb_ks_keyed_seq_core.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ks_lock_pkg.sv
// Shared types and helpers for the keyed sequence core: FSM state encoding
// and the key-chunk count derived from the key/chunk widths.
package ks_lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    OPEN,
    DEAD
  } ks_state_t;

  function automatic int nchunk(input int key_w, input int chunk_w);
    return key_w / chunk_w;
  endfunction

endpackage

// File: rtl/ks_lfsr.sv
// One combinational step of a right-shifting Galois LFSR; the caller owns the
// state register.
module ks_lfsr #(
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] TAPS   = DATA_W'(8'hB8)
) (
  input  logic [DATA_W-1:0] cur,
  output logic [DATA_W-1:0] nxt
);

  assign nxt = (cur >> 1) ^ (cur[0] ? TAPS : '0);

endmodule

// File: rtl/ks_keyed_seq_core.sv
// Key-locked accumulator: a chunked key must match GOLDEN_KEY before din is
// accumulated; while locked the accumulator free-runs as an LFSR.
module ks_keyed_seq_core
  import ks_lock_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                KEY_W      = 128,
  parameter int                CHUNK_W    = 32,
  parameter logic [KEY_W-1:0]  GOLDEN_KEY = '0,
  parameter int                MAX_TRIES  = 3,
  parameter logic [DATA_W-1:0] LFSR_SEED  = DATA_W'(8'hA5),
  parameter logic [DATA_W-1:0] LFSR_TAPS  = DATA_W'(8'hB8)
) (
  input  logic               blif_clk_net,
  input  logic               blif_reset_net,
  input  logic               sk_valid,
  output logic               sk_ready,
  input  logic [CHUNK_W-1:0] sk_chunk,
  input  logic               sk_last,
  input  logic [DATA_W-1:0]  din,
  input  logic               din_valid,
  output logic [DATA_W-1:0]  dout,
  output logic               dout_valid,
  output logic               unlocked,
  output logic               lockout
);

  localparam int NCHUNK = nchunk(KEY_W, CHUNK_W);
  localparam int CNT_W  = $clog2(NCHUNK + 1);

  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("ks_keyed_seq_core: LFSR_SEED must be nonzero");
  end
  if ((KEY_W % CHUNK_W) != 0 || MAX_TRIES < 1 || MAX_TRIES > 15 ||
      DATA_W < 4 || DATA_W > 32) begin : g_bad_params
    $error("ks_keyed_seq_core: illegal parameter combination");
  end

  ks_state_t         state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d, key_shift;
  logic [CNT_W-1:0]  count_q, count_d, count_next;
  logic [3:0]        tries_q, tries_d, tries_inc;
  logic              bad_q, bad_d;
  logic [DATA_W-1:0] acc_q, acc_d, lfsr_next;
  logic              dout_valid_q;
  logic              chunk_fire;

  ks_lfsr #(
    .DATA_W(DATA_W),
    .TAPS  (LFSR_TAPS)
  ) u_lfsr (
    .cur(acc_q),
    .nxt(lfsr_next)
  );

  assign sk_ready   = (state_q == IDLE) || (state_q == LOAD) || (state_q == OPEN);
  assign chunk_fire = sk_valid && sk_ready;
  assign unlocked   = (state_q == OPEN);
  assign lockout    = (state_q == DEAD);
  assign dout       = acc_q;
  assign dout_valid = dout_valid_q;

  assign tries_inc  = tries_q + 4'd1;
  // A chunk accepted outside LOAD always starts a fresh key sequence.
  assign count_next = (state_q == LOAD) ? count_q + CNT_W'(1) : CNT_W'(1);
  assign key_shift  = (state_q == LOAD) ? ((key_q << CHUNK_W) | KEY_W'(sk_chunk))
                                        : KEY_W'(sk_chunk);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    count_d = count_q;
    tries_d = tries_q;
    bad_d   = bad_q;
    unique case (state_q)
      IDLE, LOAD, OPEN: begin
        if (chunk_fire) begin
          key_d   = key_shift;
          count_d = count_next;
          if (sk_last) begin
            bad_d   = (count_next != CNT_W'(NCHUNK));
            state_d = CHECK;
          end else if (count_next == CNT_W'(NCHUNK)) begin
            bad_d   = 1'b1;
            state_d = CHECK;
          end else begin
            bad_d   = 1'b0;
            state_d = LOAD;
          end
        end
      end
      CHECK: begin
        if (key_q == GOLDEN_KEY && !bad_q) begin
          tries_d = '0;
          state_d = OPEN;
        end else begin
          tries_d = tries_inc;
          key_d   = '0;
          count_d = '0;
          state_d = (tries_inc == 4'(MAX_TRIES)) ? DEAD : IDLE;
        end
      end
      DEAD: begin
        state_d = DEAD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Relock reseeds so the accumulator is never zero outside OPEN.
  always_comb begin
    acc_d = lfsr_next;
    if (state_q == OPEN) begin
      if (chunk_fire) begin
        acc_d = LFSR_SEED;
      end else if (din_valid) begin
        acc_d = acc_q + din;
      end else begin
        acc_d = acc_q;
      end
    end else if (state_q == CHECK && state_d == OPEN) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge blif_clk_net) begin
    if (!blif_reset_net) begin
      state_q      <= IDLE;
      key_q        <= '0;
      count_q      <= '0;
      tries_q      <= '0;
      bad_q        <= 1'b0;
      acc_q        <= LFSR_SEED;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      count_q      <= count_d;
      tries_q      <= tries_d;
      bad_q        <= bad_d;
      acc_q        <= acc_d;
      dout_valid_q <= din_valid;
    end
  end

endmodule

// File: tb/tb_ks_keyed_seq_core.sv
// Directed bench for ks_keyed_seq_core: vector table for the unlock/datapath
// flow plus hand sequences for LFSR, reset, bad keys and lockout.
module tb_ks_keyed_seq_core;

  localparam logic [127:0] KEY = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] BAD = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;

  logic        blif_clk_net   = 1'b0;
  logic        blif_reset_net = 1'b0;
  logic        sk_valid       = 1'b0;
  logic        sk_ready;
  logic [31:0] sk_chunk       = '0;
  logic        sk_last        = 1'b0;
  logic [7:0]  din            = '0;
  logic        din_valid      = 1'b0;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        unlocked;
  logic        lockout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sk_valid;
    logic [31:0] chunk;
    logic        sk_last;
    logic        din_valid;
    logic [7:0]  din;
    logic        exp_ready;
    logic        exp_unlocked;
    logic        exp_dout_valid;
    logic        dout_chk;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t vecs [12];

  always #5 blif_clk_net = ~blif_clk_net;

  ks_keyed_seq_core #(
    .GOLDEN_KEY(KEY)
  ) dut (
    .blif_clk_net  (blif_clk_net),
    .blif_reset_net(blif_reset_net),
    .sk_valid      (sk_valid),
    .sk_ready      (sk_ready),
    .sk_chunk      (sk_chunk),
    .sk_last       (sk_last),
    .din           (din),
    .din_valid     (din_valid),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .unlocked      (unlocked),
    .lockout       (lockout)
  );

  function automatic logic [7:0] lfsr8(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_ctrl(input string name, input logic ready,
                            input logic unl, input logic lock);
    check_output({name, "_ready"}, 32'(sk_ready), 32'(ready));
    check_output({name, "_unlocked"}, 32'(unlocked), 32'(unl));
    check_output({name, "_lockout"}, 32'(lockout), 32'(lock));
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next one.
  task automatic apply_stimulus(input logic sv, input logic [31:0] c,
                                input logic l, input logic dv,
                                input logic [7:0] d);
    sk_valid  = sv;
    sk_chunk  = c;
    sk_last   = l;
    din_valid = dv;
    din       = d;
    @(negedge blif_clk_net);
  endtask

  task automatic do_reset();
    sk_valid       = 1'b0;
    sk_last        = 1'b0;
    din_valid      = 1'b0;
    blif_reset_net = 1'b0;
    @(negedge blif_clk_net);
    blif_reset_net = 1'b1;
  endtask

  task automatic send_key(input logic [127:0] k, input logic with_last);
    for (int j = 0; j < 4; j++)
      apply_stimulus(1'b1, k[127-32*j -: 32], with_last && (j == 3), 1'b0, 8'h00);
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] exp_acc;
    logic [5:0] dv_pat;
    logic [7:0] hand [2];
    hand[0] = 8'hEA;
    hand[1] = 8'h75;
    dv_pat  = 6'b101101;

    //              sv  chunk         last dv  din    rdy  unl  dvo  chk  dout
    vecs[0]  = '{1'b1, 32'h01234567, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 32'h89ABCDEF, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 32'h01234567, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 32'h89ABCDEF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00};
    vecs[5]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03};
    vecs[6]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 1'b1, 8'h08};
    vecs[7]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 8'hF6, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFE};
    vecs[8]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01};
    vecs[9]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01};
    vecs[10] = '{1'b1, 32'h01234567, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[11] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hEA};

    repeat (2) @(negedge blif_clk_net);
    blif_reset_net = 1'b1;
    check_output("rst_dout", 32'(dout), 32'hA5);
    check_output("rst_dout_valid", 32'(dout_valid), 32'h0);
    check_ctrl("rst", 1'b1, 1'b0, 1'b0);

    // Locked free-run: dout walks the LFSR, dout_valid lags din_valid by one.
    exp_acc = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b0, 32'h0, 1'b0, dv_pat[i], 8'h5A);
      exp_acc = lfsr8(exp_acc);
      check_output($sformatf("lfsr%0d_dout", i), 32'(dout), 32'(exp_acc));
      check_output($sformatf("lfsr%0d_dvalid", i), 32'(dout_valid), 32'(dv_pat[i]));
      if (i < 2) check_output($sformatf("lfsr_hand%0d", i), 32'(dout), 32'(hand[i]));
    end

    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].sk_valid, vecs[i].chunk, vecs[i].sk_last,
                     vecs[i].din_valid, vecs[i].din);
      check_ctrl($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_unlocked, 1'b0);
      check_output($sformatf("vec%0d_dvalid", i), 32'(dout_valid), 32'(vecs[i].exp_dout_valid));
      if (vecs[i].dout_chk)
        check_output($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
    end

    // Reset after two chunks must discard the partial key.
    do_reset();
    apply_stimulus(1'b1, KEY[127:96], 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b1, KEY[95:64], 1'b0, 1'b0, 8'h00);
    do_reset();
    check_ctrl("midrst", 1'b1, 1'b0, 1'b0);
    check_output("midrst_dout", 32'(dout), 32'hA5);
    send_key(KEY, 1'b1);
    check_ctrl("midrst_check", 1'b0, 1'b0, 1'b0);
    idle_cycle();
    check_ctrl("midrst_open", 1'b1, 1'b1, 1'b0);

    // Three failed attempts: early sk_last, missing sk_last, wrong value.
    do_reset();
    apply_stimulus(1'b1, KEY[127:96], 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b1, KEY[95:64], 1'b1, 1'b0, 8'h00);
    check_ctrl("short_check", 1'b0, 1'b0, 1'b0);
    idle_cycle();
    check_ctrl("short_idle", 1'b1, 1'b0, 1'b0);
    send_key(KEY, 1'b0);
    check_ctrl("nolast_check", 1'b0, 1'b0, 1'b0);
    idle_cycle();
    check_ctrl("nolast_idle", 1'b1, 1'b0, 1'b0);
    send_key(BAD, 1'b1);
    check_ctrl("bad_check", 1'b0, 1'b0, 1'b0);
    idle_cycle();
    check_ctrl("dead", 1'b0, 1'b0, 1'b1);
    send_key(KEY, 1'b1);
    idle_cycle();
    idle_cycle();
    check_ctrl("dead_hold", 1'b0, 1'b0, 1'b1);
    do_reset();
    check_ctrl("dead_rst", 1'b1, 1'b0, 1'b0);
    check_output("dead_rst_dvalid", 32'(dout_valid), 32'h0);
    send_key(KEY, 1'b1);
    idle_cycle();
    check_ctrl("after_dead_open", 1'b1, 1'b1, 1'b0);
    check_output("after_dead_dout", 32'(dout), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
